// File: rtl/spi_slave_fl.sv
// spi_slave_fl: SPI mode-0 slave exposing a small byte-addressable memory.
// Opcodes: 0x05 read status, 0x03 read, 0x02 write, 0x06 set wel, 0x04 clear wel.
// All SPI inputs are resynchronized to clk and sampled on synchronized edges.
// Ports:
//   clk        system clock (rising edge)
//   rst        asynchronous active-high reset
//   ss         slave select, active low (asynchronous to clk)
//   sclk       SPI clock, idle low (asynchronous to clk)
//   mosi       serial data in, MSB first
//   miso       serial data out, MSB first
//   last_cmd   opcode of the most recently completed frame
//   frame_done one-clk pulse at the end of a frame with a full opcode
//   wel        write-enable latch
module spi_slave_fl #(
  parameter int unsigned MEM_AW   = 8,
  parameter logic [7:0]  MEM_INIT = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] last_cmd,
  output logic       frame_done,
  output logic       wel
);

  localparam int unsigned DEPTH = 1 << MEM_AW;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    RDATA  = 3'd3,
    WDATA  = 3'd4,
    STATUS = 3'd5,
    IGNORE = 3'd6
  } state_t;

  state_t state, state_nx;

  logic [1:0] ss_sync, sclk_sync, mosi_sync;
  logic       ss_d, sclk_d;
  logic       ss_s, sclk_s, mosi_s;
  logic       ss_rise, ss_fall, sclk_rise, sclk_fall;

  logic [4:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [7:0]        out_sr;
  logic [7:0]        opcode;
  logic              got_op;
  logic [MEM_AW-1:0] addr;
  logic [7:0]        mem [DEPTH];

  logic [7:0]        byte_nx;
  logic [MEM_AW-1:0] addr_nx;
  logic [MEM_AW-1:0] addr_inc;
  logic [7:0]        status_byte;

  // Synchronizers reset to 0: if ss is held low across reset, no fall is
  // seen afterwards, so the aborted frame's remaining traffic is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_d      <= 1'b0;
      sclk_d    <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[0], ss};
      sclk_sync <= {sclk_sync[0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
      ss_d      <= ss_sync[1];
      sclk_d    <= sclk_sync[1];
    end
  end

  assign ss_s      = ss_sync[1];
  assign sclk_s    = sclk_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;

  assign byte_nx     = {shreg[6:0], mosi_s};
  // Shifting the full 24-bit address through an MEM_AW-wide register keeps
  // only the low MEM_AW bits once all bits are in.
  assign addr_nx     = {addr[MEM_AW-2:0], mosi_s};
  assign addr_inc    = addr + 1'b1;
  assign status_byte = {6'b0, wel, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (ss_rise) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (ss_fall) state_nx = CMD;
        CMD: begin
          if (sclk_rise && bit_cnt == 5'd7) begin
            case (byte_nx)
              8'h05:        state_nx = STATUS;
              8'h03, 8'h02: state_nx = ADDR;
              default:      state_nx = IGNORE;
            endcase
          end
        end
        ADDR: begin
          if (sclk_rise && bit_cnt == 5'd23)
            state_nx = (opcode == 8'h03) ? RDATA : WDATA;
        end
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso       <= 1'b0;
      last_cmd   <= 8'h00;
      frame_done <= 1'b0;
      wel        <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      out_sr     <= '0;
      opcode     <= '0;
      got_op     <= 1'b0;
      addr       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= MEM_INIT;
    end else begin
      frame_done <= 1'b0;
      if (ss_rise) begin
        miso    <= 1'b0;
        bit_cnt <= '0;
        got_op  <= 1'b0;
        if (got_op) begin
          last_cmd   <= opcode;
          frame_done <= 1'b1;
          if (opcode == 8'h02) wel <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (ss_fall) begin
              bit_cnt <= '0;
              shreg   <= '0;
              got_op  <= 1'b0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              shreg <= byte_nx;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                opcode  <= byte_nx;
                got_op  <= 1'b1;
                if (byte_nx == 8'h06) wel <= 1'b1;
                if (byte_nx == 8'h04) wel <= 1'b0;
                if (byte_nx == 8'h05) out_sr <= status_byte;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          ADDR: begin
            if (sclk_rise) begin
              addr <= addr_nx;
              if (bit_cnt == 5'd23) begin
                bit_cnt <= '0;
                out_sr  <= mem[addr_nx];
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          RDATA: begin
            if (sclk_fall) begin
              miso   <= out_sr[7];
              out_sr <= {out_sr[6:0], 1'b0};
            end else if (sclk_rise) begin
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                addr    <= addr_inc;
                out_sr  <= mem[addr_inc];
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          STATUS: begin
            // Rotate so the status byte repeats for as long as ss stays low.
            if (sclk_fall) begin
              miso   <= out_sr[7];
              out_sr <= {out_sr[6:0], out_sr[7]};
            end
          end
          WDATA: begin
            if (sclk_rise) begin
              shreg <= byte_nx;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                addr    <= addr_inc;
                if (wel) mem[addr] <= byte_nx;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/spi_slave_fl.md
SPI_SLAVE_FL -- requirements
Module: spi_slave_fl

Interface
REQ-001 SHALL have parameter MEM_AW, default 8, memory address width (memory depth 2**MEM_AW bytes).
REQ-002 SHALL have parameter MEM_INIT, default 8'hFF, reset value of every memory byte.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ss  input  1  SPI slave select, active low, asynchronous to clk.
REQ-006 SHALL have port sclk  input  1  SPI clock, mode 0 (idle low), asynchronous to clk.
REQ-007 SHALL have port mosi  input  1  SPI data from master, MSB first.
REQ-008 SHALL have port miso  output  1  SPI data to master, MSB first.
REQ-009 SHALL have port last_cmd  output  8  opcode of the most recently completed frame.
REQ-010 SHALL have port frame_done  output  1  one-clk pulse when a frame ends.
REQ-011 SHALL have port wel  output  1  write-enable latch.

Function
REQ-012 ss, sclk and mosi SHALL each pass through a 2-flop synchronizer; sclk and ss edges SHALL be detected on the synchronized signals.
REQ-013 Operation SHALL be guaranteed when sclk high and low phases are each >= 3 clk periods and mosi is stable 2 clk periods around each sclk rise.
REQ-014 mosi SHALL be sampled on synchronized sclk rise; miso SHALL update on synchronized sclk fall.
REQ-015 FSM states: IDLE, CMD, ADDR, RDATA, WDATA, STATUS, IGNORE.
REQ-016 ss fall: IDLE->CMD, bit counter cleared; ss rise in any state: ->IDLE within 1 clk after synchronized edge.
REQ-017 CMD: after 8 sampled bits the opcode is latched, then: 0x05->STATUS, 0x03->ADDR, 0x02->ADDR, 0x06 sets wel->IGNORE, 0x04 clears wel->IGNORE, any other opcode->IGNORE.
REQ-018 ADDR: 24 bits shifted in; address[MEM_AW-1:0] retained, upper bits ignored; then ->RDATA (0x03) or WDATA (0x02).
REQ-019 STATUS: status byte = {6'b0, wel, 1'b0} (bit0 WIP always 0); MSB driven on the sclk fall after the 8th opcode bit; byte repeats while ss low.
REQ-020 RDATA: byte at address loaded into shift register and MSB driven on the sclk fall after the last address bit; after each 8 bits the address increments, wrapping 2**MEM_AW-1 -> 0.
REQ-021 WDATA: every 8 complete bits written to memory at address when wel=1, then address increments with same wrap; write discarded when wel=0.
REQ-022 Partial bytes (fewer than 8 bits before ss rise) SHALL be discarded, never written.
REQ-023 At ss rise after a 0x02 frame, wel SHALL clear (whether or not data were written).
REQ-024 At ss rise, if at least 8 opcode bits were received, last_cmd SHALL take the opcode and frame_done SHALL pulse high for exactly 1 clk; otherwise neither SHALL change.
REQ-025 miso SHALL be 0 in IDLE, CMD, ADDR, WDATA, IGNORE.
REQ-026 IGNORE: all further sclk activity ignored until ss rise.

Reset
REQ-027 rst high SHALL immediately force: state IDLE, miso 0, last_cmd 8'h00, frame_done 0, wel 0, counters and shift registers 0, memory MEM_INIT.
REQ-028 rst asserted mid-frame SHALL abort the frame with no memory write; after rst release, activity SHALL be ignored until the next ss fall.

Verification
REQ-029 Frame 0x05 then 16 clocks -> miso returns 8'h00 twice; frame_done pulses once; last_cmd=8'h05.
REQ-030 Frame 0x06; frame 0x05 -> status 8'h02; frame 0x02, addr 24'h555555, data 8'h5A,8'hA3 -> wel=0 after frame; frame 0x03, addr 24'h555555 -> miso returns 8'h5A, 8'hA3.
REQ-031 Frame 0x02 with wel=0, addr 24'h000010, data 8'h12 -> read at 24'h000010 returns 8'hFF.
REQ-032 wel=1, write at addr 24'h0000FF bytes 8'h11,8'h22 -> read at 24'h0000FF returns 8'h11 then 8'h22 (addr 0).
REQ-033 Frame 0x02 ended after 5 data bits -> no write; ss toggled low-high with 3 sclk pulses -> no frame_done.
REQ-034 rst pulsed during ADDR phase of a 0x03 frame -> miso 0, state IDLE, wel 0; next full 0x05 frame answers 8'h00.
